// File: rtl/gost512_scheduler.sv
// Work sequencer for a fully pipelined gost512 core: issues {header, nonce}
// words back to back, tracks them through the core and queues winning nonces.
module gost512_scheduler #(
  parameter int PIPE_LAT  = 117,
  parameter int RES_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [479:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic [511:0] data_out,
  input  logic [511:0] hash_in,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic         overflow
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Handshake: an entry leaves the result FIFO on a rising edge where
  // result_valid and result_ready are both high; result_nonce is the head
  // entry and stays stable while result_valid is high and ready is low.

  state_t          state, state_nx;
  logic            done_nx;
  logic [479:0]    header_q;
  logic [63:0]     target_q;
  logic [31:0]     end_q;
  logic [32:0]     cnt_q;
  logic [31:0]     ret_nonce;
  logic [PIPE_LAT:0] vpipe;
  logic [DW-1:0]   drain_cnt;
  logic [31:0]     mem [RES_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;

  logic issue, accept, last, tap_valid, win, full, empty, pop, push_ok;
  logic unused_hash;

  assign unused_hash = ^hash_in[447:0];

  assign issue     = (state == RUN);
  assign accept    = (state == IDLE) && start && !abort;
  assign last      = (cnt_q == {1'b0, end_q});
  // vpipe has one stage more than PIPE_LAT: the word is captured by the core at
  // edge k and its hash is only valid after edge k+PIPE_LAT.
  assign tap_valid = vpipe[PIPE_LAT];
  assign win       = tap_valid && !abort && (hash_in[511:448] <= target_q);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop     = !empty && result_ready;
  assign push_ok = win && (!full || pop);

  assign data_out     = {header_q, cnt_q[31:0]};
  assign busy         = (state != IDLE);
  assign result_valid = !empty;
  assign result_nonce = mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = (nonce_start > nonce_end) ? DRAIN : RUN;
      RUN:   if (last) state_nx = DRAIN;
      DRAIN: if (drain_cnt == '0) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      header_q  <= '0;
      target_q  <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      ret_nonce <= '0;
      vpipe     <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (accept) begin
        header_q  <= header;
        target_q  <= target;
        end_q     <= nonce_end;
        cnt_q     <= {1'b0, nonce_start};
        ret_nonce <= nonce_start;
      end else begin
        // The counter holds on the last word so data_out keeps it through DRAIN.
        if (issue && !last) cnt_q <= cnt_q + 33'd1;
        // Words return in issue order, so the returning nonce is just a count.
        if (tap_valid) ret_nonce <= ret_nonce + 32'd1;
      end
      if (abort) vpipe <= '0;
      else       vpipe <= {vpipe[PIPE_LAT-1:0], issue};
      if (abort || accept)             drain_cnt <= '0;
      else if (issue && last)          drain_cnt <= DW'(PIPE_LAT);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (accept)                    overflow <= 1'b0;
      else if (win && full && !pop)  overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= ret_nonce;
  end

endmodule

// File: doc/gost512_scheduler.md
Name: gost512_scheduler

Overview:
- Work sequencer for the fully pipelined gost512 core (one hash per clock, no stall).
- Latches a 480-bit header, a nonce range and a 64-bit target, and issues one {header, nonce} word per cycle into the core.
- Tracks in-flight words with a valid shift register aligned to the core latency, compares each returned hash against the target, and queues winning nonces in a small result FIFO with a valid/ready handshake.

Parameters:
- PIPE_LAT, 117, cycles from data_out sampled at edge k to the matching hash_in being stable after edge k+PIPE_LAT (gost512: 1 + 4×29).
- RES_DEPTH, 4, result FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job launch; ignored while busy.
- abort  in  1  cancel current job.
- header  in  480  work header; sampled only on accepted start.
- nonce_start  in  32  first nonce (inclusive); sampled on start.
- nonce_end  in  32  last nonce (inclusive); sampled on start.
- target  in  64  threshold; sampled on start.
- data_out  out  512  to gost512 data: {header_q, nonce_q}.
- hash_in  in  512  from gost512 hash.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  one-cycle pulse at normal job completion.
- result_valid  out  1  FIFO not empty.
- result_ready  in  1  consumer pop.
- result_nonce  out  32  FIFO head nonce.
- overflow  out  1  sticky: a winning result was dropped.

Behaviour:
- Reset, asynchronous: state IDLE; busy, done, result_valid, overflow = 0; FIFO empty; valid pipe all 0; header_q, nonce_q, target_q = 0, so data_out = 0.
- FSM IDLE→RUN: start sampled in IDLE at edge 0 latches header/target/range and sets a 33-bit counter to nonce_start.
  - If nonce_start > nonce_end: no word issued; done pulses after edge 1; back to IDLE.
  - Start also clears overflow.
- RUN: each cycle data_out = {header_q, counter[31:0]} with issue = 1. Counter increments every edge.
  - When the issued nonce equals nonce_end, go to DRAIN.
  - nonce_end = 0xFFFFFFFF must terminate; the 33-bit counter never wraps to 0.
  - N = end − start + 1 words are issued at edges 1..N.
- DRAIN: issue = 0; data_out holds its last value. A down-counter loaded with PIPE_LAT expires when the last word's hash has been compared.
  - done pulses after edge N+PIPE_LAT+1; state returns to IDLE; busy falls with done.
- Valid tracking: a PIPE_LAT-bit shift register carries issue. A nonce delay line of equal length carries counter[31:0]; an equivalent arithmetic reconstruction is allowed if bit-exact.
- Compare: when the tap valid = 1 and hash_in[511:448] ≤ target_q (unsigned), push the tap nonce into the FIFO at the next edge. Equality counts as a win.
- FIFO:
  - Pop on result_valid & result_ready.
  - Push and pop in the same cycle while full both succeed.
  - Push while full without pop: drop the entry and set overflow.
  - FIFO order is issue order.
- Abort, any state: next edge goes to IDLE; valid pipe and drain counter cleared, so in-flight words produce no results.
  - FIFO contents are kept; no done pulse.
  - start in the same cycle as abort is ignored.
- start while busy: ignored; latched values unchanged.
- Reset mid-job: immediate return to reset values, including FIFO flush.

Test Plan:
- Bench replaces gost512 with a PIPE_LAT delay line mapping hash[511:448] = {32'd0, nonce}. start=[0x10..0x13], target=0x11 → exactly nonces 0x10, 0x11 pushed in order; done pulses 4+117+1 = 122 edges after start; busy high for edges 0..121.
- Range nonce_start=0xFFFFFFFE, nonce_end=0xFFFFFFFF, target=max → 2 results (…FE, …FF), then done; no further issue and no wrap to 0.
- nonce_start=5, nonce_end=4 → done pulses after edge 1; no data issued; FIFO stays empty.
- target=max, range of 8, result_ready=0 → FIFO holds 0..3, overflow=1. Raising result_ready pops 0,1,2,3. A new start clears overflow.
- Abort at edge 50 of a 100-nonce run with target=max → FIFO contents from before abort retained; no results from nonces issued later or still in flight; no done; state IDLE after edge 51.
- Assert rst asynchronously mid-DRAIN → all outputs at reset values immediately, before the next edge; FIFO empty. Restart works normally.
